afifo_rd_drain: RTL and testbench

- Read-side consumer for the async FIFO; sits entirely in the read clock domain, between the FIFO read port and the downstream SM.
- Issues read requests to the FIFO and accounts for the fixed SRAM output-register latency.
- Captures returned words into a small local prefetch buffer and presents them downstream with a valid/full handshake.
- Provides flush, a delivered-word counter and a sticky overflow error.

---
 rtl/afifo_rd_drain_if.sv | 33 +++
 rtl/afifo_rd_drain.sv | 161 ++++++++++++++++
 tb/tb_afifo_rd_drain.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/afifo_rd_drain_if.sv
// Purpose: groups the FIFO read port and the downstream SM handshake of the read-side drain.
// Latency: none. This file only bundles wires.
// Backpressure: sm_full from the SM holds sm_d. fifo_empty from the FIFO gates fifo_rd.
interface afifo_rd_drain_if #(
    parameter int DW = 32
);
    logic          fifo_empty;
    logic          fifo_rd;
    logic [DW-1:0] fifo_d;
    logic [DW-1:0] sm_d;
    logic          sm_vld;
    logic          sm_full;

    // Drain side: drives FIFO read requests and the SM data/valid
    modport master (
        input  fifo_empty,
        input  fifo_d,
        input  sm_full,
        output fifo_rd,
        output sm_d,
        output sm_vld
    );

    // Environment side: FIFO model plus SM sink
    modport slave (
        output fifo_empty,
        output fifo_d,
        output sm_full,
        input  fifo_rd,
        input  sm_d,
        input  sm_vld
    );
endinterface

// File: rtl/afifo_rd_drain.sv
// Purpose: read-clock-domain consumer. It requests FIFO words, absorbs the SRAM read latency, and prefetches into a small buffer for the SM.
// Latency: fifo_rd in cycle N gives sm_vld in cycle N+RD_LAT+1.
// Backpressure: sm_full holds the head word. Requests stop once buffered plus in-flight words reach DEPTH.
module afifo_rd_drain #(
    parameter int DW     = 32,
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    afifo_rd_drain_if.master   bus,
    input  logic               flush,
    input  logic               en,
    output logic               busy,
    output logic               ovf_err,
    output logic [CNT_W-1:0]   rx_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL = PW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   count;
    logic [RD_LAT-1:0] infl;
    logic [PW:0]     infl_cnt;
    logic [PW:0]     occ;
    logic [DW-1:0]   mem [DEPTH];
    logic            rd_req;
    logic            fifo_rd_i;
    logic            sm_vld_i;
    logic            cap;
    logic            discard;
    logic            pop;
    logic            store;
    logic            ovf_set;

    // Occupancy bookkeeping: buffered words plus words still coming back from the SRAM
    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            infl_cnt = infl_cnt + {{PW{1'b0}}, infl[i]};
        end
        count    = wptr - rptr;
        occ      = {1'b0, count} + infl_cnt;
        sm_vld_i = (count != '0);
        cap      = infl[RD_LAT-1];
        // During a flush, and in FLUSH, returning words are dropped silently
        discard  = flush || (state == FLUSH);
        // A flush empties the buffer outright, so it must not also count a pop
        pop      = sm_vld_i && !bus.sm_full && !flush;
        // A full buffer can still take a word when the head leaves in the same cycle
        store    = cap && !discard && ((count != FULL) || pop);
        ovf_set  = cap && !discard && (count == FULL) && !pop;
    end

    // Next-state and read-issue decode
    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_nxt = FLUSH;
                end else if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                rd_req = en && !bus.fifo_empty && !flush && (occ < {1'b0, FULL});
                if (flush) begin
                    state_nxt = FLUSH;
                end else if (!en) begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if ((infl == '0) && !flush) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A word requested during the reset cycle would be lost, so no request is issued then
    assign fifo_rd_i   = rd_req && !rst;
    assign bus.fifo_rd = fifo_rd_i;
    assign bus.sm_vld  = sm_vld_i;
    assign bus.sm_d    = sm_vld_i ? mem[rptr[AW-1:0]] : '0;
    assign busy        = (state != IDLE) || sm_vld_i;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // In-flight shift register: bit RD_LAT-1 marks the cycle fifo_d carries our word
    always_ff @(posedge clk) begin
        if (rst) begin
            infl <= '0;
        end else begin
            infl[0] <= fifo_rd_i;
            for (int i = 1; i < RD_LAT; i++) begin
                infl[i] <= infl[i-1];
            end
        end
    end

    // Buffer pointers. A flush snaps rptr onto wptr, which empties the buffer in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            rptr <= wptr;
        end else begin
            if (store) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

    // Buffer storage needs no reset: sm_d is masked while the buffer is empty
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wptr[AW-1:0]] <= bus.fifo_d;
        end
    end

    // Delivered-word counter and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt  <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (pop) begin
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
            if (ovf_set) begin
                ovf_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_afifo_rd_drain.sv
// Purpose: checks afifo_rd_drain at RD_LAT=1 and RD_LAT=2 side by side against a queue-based model.
// Latency: the model predicts every output for every cycle.
// Backpressure: sm_full, fifo_empty, flush, en and rst are driven by directed phases, then randomly.
module tb_afifo_rd_drain;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst        = 1'b1;
    logic en         = 1'b0;
    logic flush      = 1'b0;
    logic fifo_empty = 1'b1;
    logic sm_full    = 1'b0;
    bit   go         = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Inputs for one cycle are applied at the falling edge
    task automatic tick(input int r, input int e, input int f, input int emp, input int full);
        @(negedge clk);
        rst        = (r != 0);
        en         = (e != 0);
        flush      = (f != 0);
        fifo_empty = (emp != 0);
        sm_full    = (full != 0);
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = g + 1;

        afifo_rd_drain_if #(.DW(DW)) bus ();
        logic             busy;
        logic             ovf_err;
        logic [CNT_W-1:0] rx_cnt;
        logic [DW-1:0]    fd = '0;

        assign bus.fifo_empty = fifo_empty;
        assign bus.sm_full    = sm_full;
        assign bus.fifo_d     = fd;

        afifo_rd_drain #(
            .DW(DW), .DEPTH(DEPTH), .RD_LAT(LAT), .CNT_W(CNT_W)
        ) dut (
            .clk(clk), .rst(rst), .bus(bus), .flush(flush), .en(en),
            .busy(busy), .ovf_err(ovf_err), .rx_cnt(rx_cnt)
        );

        // Model state: buffered words, outstanding requests (due cycle + data), mode 0 idle / 1 run / 2 flushing
        logic [DW-1:0] mbuf [$];
        logic [DW-1:0] fl_dat [$];
        int            fl_due [$];
        int            mode = 0;
        int            cyc  = 0;
        int            seq  = 0;
        int            rxm  = 0;
        bit            ovfm = 1'b0;
        bit            exp_vld, exp_rd, cap, popm, full_before;
        int            n_infl;
        logic [DW-1:0] exp_d, capd, w;

        always @(negedge clk) begin
            if (go) begin
                #1;
                // Upstream FIFO: our word is on fifo_d exactly in its due cycle, junk otherwise
                if (fl_due.size() != 0 && fl_due[0] == cyc) fd = fl_dat[0];
                else fd = $urandom;

                exp_vld = (mbuf.size() != 0);
                exp_d   = exp_vld ? mbuf[0] : '0;
                n_infl  = fl_due.size();
                exp_rd  = !rst && (mode == 1) && en && !fifo_empty && !flush &&
                          (mbuf.size() + n_infl < DEPTH);

                check($sformatf("L%0d fifo_rd", LAT), 64'(bus.fifo_rd), 64'(exp_rd));
                check($sformatf("L%0d sm_vld", LAT),  64'(bus.sm_vld),  64'(exp_vld));
                check($sformatf("L%0d sm_d", LAT),    64'(bus.sm_d),    64'(exp_d));
                check($sformatf("L%0d busy", LAT),    64'(busy),        64'((mode != 0) || exp_vld));
                check($sformatf("L%0d ovf_err", LAT), 64'(ovf_err),     64'(ovfm));
                check($sformatf("L%0d rx_cnt", LAT),  64'(rx_cnt),      64'(rxm % 65536));

                if (rst) begin
                    mbuf.delete();
                    fl_due.delete();
                    fl_dat.delete();
                    mode = 0;
                    rxm  = 0;
                    ovfm = 1'b0;
                end else begin
                    cap  = (n_infl != 0) && (fl_due[0] == cyc);
                    capd = cap ? fl_dat[0] : '0;
                    if (cap) begin
                        void'(fl_due.pop_front());
                        void'(fl_dat.pop_front());
                    end
                    popm = exp_vld && !sm_full && !flush;
                    if (flush) begin
                        mbuf.delete();
                    end else begin
                        full_before = (mbuf.size() == DEPTH);
                        if (popm) begin
                            void'(mbuf.pop_front());
                            rxm++;
                        end
                        if (cap && mode != 2) begin
                            if (full_before && !popm) ovfm = 1'b1;
                            else mbuf.push_back(capd);
                        end
                    end
                    if (exp_rd) begin
                        w = $urandom;
                        w[7:0] = 8'hA0 + seq[7:0];
                        fl_due.push_back(cyc + LAT);
                        fl_dat.push_back(w);
                        seq++;
                    end
                    case (mode)
                        0: if (flush) mode = 2; else if (en) mode = 1;
                        1: if (flush) mode = 2; else if (!en) mode = 0;
                        default: if (n_infl == 0 && !flush) mode = 0;
                    endcase
                end
                cyc++;
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        go = 1'b1;
        tick(1, 0, 0, 1, 0);
        // Free-running stream
        repeat (14) tick(0, 1, 0, 0, 0);
        // SM stalls: requests stop at DEPTH, head word held
        repeat (12) tick(0, 1, 0, 0, 1);
        // Single-cycle release while full, then hold, then drain
        tick(0, 1, 0, 0, 0);
        repeat (4) tick(0, 1, 0, 0, 1);
        repeat (6) tick(0, 1, 0, 0, 0);
        // Flush with words buffered and in flight
        repeat (6) begin
            repeat (3 + $urandom_range(0, 3)) tick(0, 1, 0, 0, int'($urandom_range(0, 1)));
            tick(0, 1, 1, 0, 1);
            repeat (3) tick(0, 1, 0, 0, 0);
        end
        // fifo_empty toggling every cycle
        for (int i = 0; i < 40; i++) tick(0, 1, 0, i % 2, int'($urandom_range(0, 3) == 0));
        // Reset mid-stream with a full buffer and returns pending
        repeat (4) tick(0, 1, 0, 0, 1);
        tick(1, 1, 0, 0, 1);
        repeat (4) tick(0, 1, 0, 0, 0);
        // en dropped with returns in flight, then flush while idle
        repeat (3) begin
            repeat (3) tick(0, 1, 0, 0, 0);
            tick(0, 0, 0, 0, 1);
            repeat (3) tick(0, 0, 0, 0, 0);
        end
        tick(0, 0, 1, 0, 0);
        repeat (3) tick(0, 0, 0, 0, 0);
        // Random soak
        for (int i = 0; i < 3000; i++) begin
            tick(int'($urandom_range(0, 99) == 0), int'($urandom_range(0, 9) != 0),
                 int'($urandom_range(0, 19) == 0), int'($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 9) < 4));
        end
        @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
